// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - shared state encoding and counter saturation helper for minmax_seq
package minmax_pkg;

  typedef enum logic [2:0] {
    S_FIRST,
    S_ACCEPT,
    S_CMP_MIN,
    S_CMP_MAX,
    S_DONE
  } state_t;

  localparam int CNT_W_DEFAULT = 16;

  // All-ones value of a w-bit counter; the top casts it to its own CNT_W.
  function automatic longint unsigned cnt_sat(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sltu.sv
// rtl/sltu.sv - N-bit unsigned less-than comparator (lt = a < b)
module sltu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/minmax_seq.sv
// rtl/minmax_seq.sv - streaming unsigned min/max sequencer sharing one sltu comparator
// Optional MINMAX_INDEX_EN adds out_min_idx/out_max_idx (zero-based position of first occurrence).
module minmax_seq
  import minmax_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [CNT_W-1:0] out_count
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  state_t       state;
  logic [N-1:0] hold;
  logic         last_q;
  logic [N-1:0] cmp_a;
  logic [N-1:0] cmp_b;
  logic         lt;

  // Operands depend on state only; outside the compare states the result is ignored.
  always_comb begin
    cmp_a = hold;
    cmp_b = out_min;
    if (state == S_CMP_MAX) begin
      cmp_a = out_max;
      cmp_b = hold;
    end
  end

  sltu #(.N(N)) u_sltu (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (lt)
  );

  assign in_ready = (state == S_FIRST) || (state == S_ACCEPT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FIRST;
      out_valid <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
      hold      <= '0;
      last_q    <= 1'b0;
`ifdef MINMAX_INDEX_EN
      out_min_idx <= '0;
      out_max_idx <= '0;
`endif
    end else begin
      case (state)
        S_FIRST: begin
          if (in_valid) begin
            out_min   <= in_data;
            out_max   <= in_data;
            out_count <= CNT_W'(1);
`ifdef MINMAX_INDEX_EN
            out_min_idx <= '0;
            out_max_idx <= '0;
`endif
            if (in_last) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            hold   <= in_data;
            last_q <= in_last;
            if (out_count != CNT_MAX) out_count <= out_count + 1'b1;
            state  <= S_CMP_MIN;
          end
        end
        // Strict less-than: ties keep the earlier word and its index.
        S_CMP_MIN: begin
          if (lt) begin
            out_min <= hold;
`ifdef MINMAX_INDEX_EN
            out_min_idx <= out_count - 1'b1;
`endif
          end
          state <= S_CMP_MAX;
        end
        S_CMP_MAX: begin
          if (lt) begin
            out_max <= hold;
`ifdef MINMAX_INDEX_EN
            out_max_idx <= out_count - 1'b1;
`endif
          end
          if (last_q) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            state <= S_ACCEPT;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_FIRST;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_FIRST;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_seq.sv
// tb/tb_minmax_seq.sv - directed and randomized self-checking bench for minmax_seq
module tb_minmax_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_min;
  logic [31:0] out_max;
  logic [15:0] out_count;
`ifdef MINMAX_INDEX_EN
  logic [15:0] out_min_idx;
  logic [15:0] out_max_idx;
`endif

  int errors = 0;
  int checks = 0;

  minmax_seq #(.N(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
`ifdef MINMAX_INDEX_EN
    ,
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic put(input logic [31:0] d, input logic l, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL put_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [31:0] emin, input logic [31:0] emax,
                            input logic [15:0] ecnt, input logic [15:0] emin_i,
                            input logic [15:0] emax_i, input int delay);
    int t;
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid_timeout: got %b required 1", name, out_valid);
    end
    checks++;
    if (out_min !== emin) begin
      errors++;
      $display("FAIL %s out_min: got %h required %h", name, out_min, emin);
    end
    checks++;
    if (out_max !== emax) begin
      errors++;
      $display("FAIL %s out_max: got %h required %h", name, out_max, emax);
    end
    checks++;
    if (out_count !== ecnt) begin
      errors++;
      $display("FAIL %s out_count: got %0d required %0d", name, out_count, ecnt);
    end
`ifdef MINMAX_INDEX_EN
    checks++;
    if (out_min_idx !== emin_i || out_max_idx !== emax_i) begin
      errors++;
      $display("FAIL %s idx: got %0d/%0d required %0d/%0d", name, out_min_idx, out_max_idx,
               emin_i, emax_i);
    end
`endif
    repeat (delay) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid_drop: got %b required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_min !== 32'h0 || out_max !== 32'h0 || out_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got %h/%h/%0d required 0/0/0", out_min, out_max, out_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    put(32'd5, 1'b1, 0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: out_valid=%b required 1", out_valid);
    end
    get_result("single", 32'd5, 32'd5, 16'd1, 16'd0, 16'd0, 0);
  endtask

  task automatic test_stream();
    logic [31:0] v [4];
    int acc [4];
    int idx;
    int cyc;
    v[0] = 32'd7; v[1] = 32'd3; v[2] = 32'd9; v[3] = 32'd3;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[idx];
      in_last  = (idx == 3);
      if (in_ready) begin
        acc[idx] = cyc;
        idx++;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (idx != 4 || acc[1] - acc[0] != 1 || acc[2] - acc[1] != 3 || acc[3] - acc[2] != 3) begin
      errors++;
      $display("FAIL stream_spacing: got accepts=%0d gaps %0d,%0d,%0d required 4 gaps 1,3,3",
               idx, acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency0: out_valid=%b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency1: out_valid=%b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_latency2: out_valid=%b required 1", out_valid);
    end
    get_result("stream", 32'd3, 32'd9, 16'd4, 16'd1, 16'd2, 1);
  endtask

  task automatic test_unsigned_boundary();
    put(32'h8000_0000, 1'b0, 0);
    put(32'hFFFF_FFFF, 1'b0, 0);
    put(32'h0000_0000, 1'b1, 0);
    get_result("unsigned", 32'h0, 32'hFFFF_FFFF, 16'd3, 16'd2, 16'd1, 0);
  endtask

  task automatic test_backpressure();
    put(32'd10, 1'b0, 0);
    put(32'd20, 1'b1, 0);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_data  = 32'd99;
      in_last  = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== 32'd10 ||
          out_max !== 32'd20 || out_count !== 16'd2) begin
        errors++;
        $display("FAIL backpressure_%0d: got v=%b r=%b %0d/%0d/%0d required 1/0 10/20/2", k,
                 out_valid, in_ready, out_min, out_max, out_count);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    get_result("backpressure", 32'd10, 32'd20, 16'd2, 16'd0, 16'd1, 0);
  endtask

  task automatic test_reset_mid_burst();
    put(32'd100, 1'b0, 0);
    put(32'd50, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: got r=%b v=%b cnt=%0d required 1/0/0", in_ready, out_valid,
               out_count);
    end
    @(negedge clk);
    rst = 1'b0;
    put(32'd4, 1'b1, 0);
    get_result("midreset", 32'd4, 32'd4, 16'd1, 16'd0, 16'd0, 0);
  endtask

  task automatic test_random();
    logic [31:0] d, mn, mx;
    logic [15:0] mn_i, mx_i;
    int len;
    for (int b = 0; b < 512; b++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        d = $urandom;
        if (i == 0) begin
          mn = d; mx = d; mn_i = 16'd0; mx_i = 16'd0;
        end else begin
          if (d < mn) begin mn = d; mn_i = 16'(i); end
          if (d > mx) begin mx = d; mx_i = 16'(i); end
        end
        put(d, (i == len - 1), $urandom_range(0, 2));
      end
      get_result("random", mn, mx, 16'(len), mn_i, mx_i, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_unsigned_boundary();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
